// File: rtl/cust_iir_filter_mc.sv
// Multi-channel first-order IIR filter (bypass / low-pass / high-pass).
// One shared datapath walks each accepted sample through a 5-state FSM.
module cust_iir_filter_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEFF_WIDTH  = 16,
    parameter int CHANNELS     = 32,
    parameter int CHANNELS_PW2 = 7,
    parameter int SIGNED_IN    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   chan_in_sample,
    input  logic [CHANNELS_PW2-1:0] chan_in_num,
    input  logic                    chan_in_valid,
    output logic                    chan_in_read,
    output logic [DATA_WIDTH-1:0]   chan_out_sample,
    output logic [CHANNELS_PW2-1:0] chan_out_num,
    output logic                    chan_out_valid,
    input  logic                    chan_out_read,
    input  logic [COEFF_WIDTH-1:0]  coeff,
    input  logic [1:0]              mode,
    input  logic                    clear_state
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = COEFF_WIDTH;
    localparam int SW = DW + CW;
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {
        CLEAR, IDLE, READ, CALC, WRITE, OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           sample_q, sample_d;
    logic [CHANNELS_PW2-1:0] num_q, num_d;
    logic [CW-1:0]           coeff_q, coeff_d;
    logic [1:0]              mode_q, mode_d;
    logic                    oor_q, oor_d;
    logic                    pend_q, pend_d;
    logic signed [SW-1:0]    s_q, s_d;
    logic signed [SW-1:0]    snew_q, snew_d;
    logic                    in_read_q, in_read_d;
    logic                    out_valid_q, out_valid_d;
    logic [DW-1:0]           out_sample_q, out_sample_d;
    logic [CHANNELS_PW2-1:0] out_num_q, out_num_d;

    logic signed [SW-1:0]    mem [CHANNELS];
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic signed [SW-1:0]    mem_wdata;

    logic signed [DW-1:0]    x, lp, lp_new, hp_sat, res;
    logic signed [DW:0]      d, hp;
    logic signed [SW-1:0]    prod, snew_c;
    logic [DW-1:0]           res_fmt;

    // State is kept in Q.CW so the fractional part survives small coefficients
    always_comb begin
        x = sample_q;
        if (SIGNED_IN == 0) x[DW-1] = ~sample_q[DW-1];
        lp     = s_q[SW-1:CW];
        d      = {x[DW-1], x} - {lp[DW-1], lp};
        prod   = {{(SW-DW-1){d[DW]}}, d} * {{DW{1'b0}}, coeff_q};
        snew_c = s_q + prod;
        lp_new = snew_q[SW-1:CW];
        hp     = {x[DW-1], x} - {lp_new[DW-1], lp_new};
        if (hp[DW] != hp[DW-1])
            hp_sat = hp[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            hp_sat = hp[DW-1:0];
        case (mode_q)
            2'b00:   res = x;
            2'b01:   res = lp_new;
            default: res = hp_sat;
        endcase
        if (oor_q) res = x;
        res_fmt = res;
        if (SIGNED_IN == 0) res_fmt[DW-1] = ~res[DW-1];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sample_d     = sample_q;
        num_d        = num_q;
        coeff_d      = coeff_q;
        mode_d       = mode_q;
        oor_d        = oor_q;
        pend_d       = pend_q | clear_state;
        s_d          = s_q;
        snew_d       = snew_q;
        out_sample_d = out_sample_q;
        out_num_d    = out_num_q;
        mem_we       = 1'b0;
        mem_addr     = num_q[AW-1:0];
        mem_wdata    = snew_q;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == AW'(CHANNELS - 1)) begin
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q | clear_state) ? CLEAR : IDLE;
                end
            end
            IDLE: begin
                pend_d = 1'b0;
                if (clear_state) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else if (chan_in_valid) begin
                    sample_d = chan_in_sample;
                    num_d    = chan_in_num;
                    coeff_d  = coeff;
                    mode_d   = mode;
                    oor_d    = (32'(chan_in_num) >= CHANNELS);
                    state_d  = READ;
                end
            end
            READ: begin
                s_d     = oor_q ? '0 : mem[num_q[AW-1:0]];
                state_d = CALC;
            end
            CALC: begin
                snew_d  = snew_c;
                state_d = WRITE;
            end
            WRITE: begin
                mem_we       = ~oor_q;
                out_sample_d = res_fmt;
                out_num_d    = num_q;
                state_d      = OUT;
            end
            OUT: begin
                if (chan_out_read) begin
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q | clear_state) ? CLEAR : IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
        in_read_d   = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            sample_q     <= '0;
            num_q        <= '0;
            coeff_q      <= '0;
            mode_q       <= '0;
            oor_q        <= 1'b0;
            pend_q       <= 1'b0;
            s_q          <= '0;
            snew_q       <= '0;
            in_read_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_num_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sample_q     <= sample_d;
            num_q        <= num_d;
            coeff_q      <= coeff_d;
            mode_q       <= mode_d;
            oor_q        <= oor_d;
            pend_q       <= pend_d;
            s_q          <= s_d;
            snew_q       <= snew_d;
            in_read_q    <= in_read_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            out_num_q    <= out_num_d;
        end
    end

    // Channel state is zeroed by the CLEAR sweep rather than by reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign chan_in_read    = in_read_q;
    assign chan_out_valid  = out_valid_q;
    assign chan_out_sample = out_sample_q;
    assign chan_out_num    = out_num_q;

endmodule

// File: tb/tb_cust_iir_filter_mc.sv
// Bench for cust_iir_filter_mc: offset-binary and signed instances share stimulus
// and are compared against an arithmetic per-channel reference model.
module tb_cust_iir_filter_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] chan_in_sample = '0;
    logic [6:0]  chan_in_num = '0;
    logic        chan_in_valid = 1'b0;
    logic        chan_in_read;
    logic [15:0] chan_out_sample;
    logic [6:0]  chan_out_num;
    logic        chan_out_valid;
    logic        chan_out_read = 1'b0;
    logic [15:0] coeff = '0;
    logic [1:0]  mode = '0;
    logic        clear_state = 1'b0;

    logic        s_in_read;
    logic [15:0] s_out_sample;
    logic [6:0]  s_out_num;
    logic        s_out_valid;

    int checks = 0;
    int failures = 0;

    longint st_u [32];
    longint st_s [32];

    always #5 clk = ~clk;

    cust_iir_filter_mc #(.SIGNED_IN(0)) u_dut (
        .clk(clk), .reset(reset),
        .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
        .chan_in_valid(chan_in_valid), .chan_in_read(chan_in_read),
        .chan_out_sample(chan_out_sample), .chan_out_num(chan_out_num),
        .chan_out_valid(chan_out_valid), .chan_out_read(chan_out_read),
        .coeff(coeff), .mode(mode), .clear_state(clear_state)
    );

    cust_iir_filter_mc #(.SIGNED_IN(1)) u_dut_s (
        .clk(clk), .reset(reset),
        .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
        .chan_in_valid(chan_in_valid), .chan_in_read(s_in_read),
        .chan_out_sample(s_out_sample), .chan_out_num(s_out_num),
        .chan_out_valid(s_out_valid), .chan_out_read(chan_out_read),
        .coeff(coeff), .mode(mode), .clear_state(clear_state)
    );

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) begin
            st_u[i] = 0;
            st_s[i] = 0;
        end
    endfunction

    // y[n] = lp + c*(x - lp) in Q16, output chosen by mode
    function automatic logic [15:0] ref_step(input bit sgn, input logic [15:0] smp,
                                             input int ch, input int c, input int m);
        longint x, lp, s, y;
        if (ch >= 32) return smp;
        x  = sgn ? longint'($signed(smp)) : longint'(smp) - 32768;
        s  = sgn ? st_s[ch] : st_u[ch];
        lp = s >>> 16;
        s  = s + (x - lp) * longint'(c);
        if (sgn) st_s[ch] = s;
        else st_u[ch] = s;
        lp = s >>> 16;
        if (m == 0) y = x;
        else if (m == 1) y = lp;
        else begin
            y = x - lp;
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
        end
        if (!sgn) y = y + 32768;
        return 16'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!chan_in_read && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic xact(input logic [15:0] smp, input int ch, input int c, input int m,
                        input int stall, input bit clr,
                        output logic [15:0] got_u, output logic [15:0] got_s);
        logic [15:0] eu, es;
        int n;
        bit ok;
        chan_in_sample = smp;
        chan_in_num    = 7'(ch);
        coeff          = 16'(c);
        mode           = 2'(m);
        chan_in_valid  = 1'b1;
        wait_ready(n);
        check("accept_wait", 32'(n < 200), 1);
        eu = ref_step(1'b0, smp, ch, c, m);
        es = ref_step(1'b1, smp, ch, c, m);
        tick();
        chan_in_valid = 1'b0;
        coeff = 16'($urandom);
        mode  = 2'($urandom);
        if (clr) begin
            tick();
            clear_state = 1'b1;
            tick();
            clear_state = 1'b0;
        end
        n = 0;
        while (!chan_out_valid && n < 50) begin
            tick();
            n++;
        end
        check("out_valid", 32'(chan_out_valid), 1);
        if (!clr) check("latency", n, 3);
        ok = 1'b1;
        repeat (stall) begin
            tick();
            if (!(chan_out_valid && !chan_in_read && chan_out_sample == eu &&
                  chan_out_num == 7'(ch) && s_out_sample == es))
                ok = 1'b0;
        end
        if (stall > 0) check("stall_hold", 32'(ok), 1);
        check("out_sample_u", 32'(chan_out_sample), 32'(eu));
        check("out_sample_s", 32'(s_out_sample), 32'(es));
        check("out_num", 32'(chan_out_num), 32'(ch));
        check("valid_s", 32'(s_out_valid), 1);
        got_u = chan_out_sample;
        got_s = s_out_sample;
        chan_out_read = 1'b1;
        tick();
        chan_out_read = 1'b0;
        check("valid_drop", 32'(chan_out_valid), 0);
        if (clr) begin
            clear_model();
            wait_ready(n);
            check("clear_len", n, 32);
        end
    endtask

    initial begin
        logic [15:0] gu, gs;
        int n;
        clear_model();
        repeat (3) tick();
        check("rst_in_read", 32'(chan_in_read), 0);
        check("rst_out_valid", 32'(chan_out_valid), 0);
        check("rst_out_sample", 32'(chan_out_sample), 0);
        check("rst_out_num", 32'(chan_out_num), 0);

        reset = 1'b1;
        wait_ready(n);
        check("init_clear_len", n, 32);

        xact(16'd33768, 3, 32768, 2, 0, 1'b0, gu, gs);
        check("hp_first", 32'(gu), 33268);
        xact(16'd33768, 3, 32768, 2, 0, 1'b0, gu, gs);
        check("hp_second", 32'(gu), 33018);

        xact(16'd33768, 5, 32768, 1, 0, 1'b0, gu, gs);
        check("lp_first", 32'(gu), 33268);
        xact(16'd33768, 3, 32768, 1, 0, 1'b0, gu, gs);
        xact(16'd33768, 5, 32768, 1, 0, 1'b0, gu, gs);
        check("lp_second", 32'(gu), 33518);

        xact(16'($urandom), 7, 20000, 2, 10, 1'b0, gu, gs);

        xact(16'd40000, 3, 32768, 2, 0, 1'b1, gu, gs);
        xact(16'd33768, 3, 32768, 2, 0, 1'b0, gu, gs);
        check("hp_after_clear", 32'(gu), 33268);

        chan_in_sample = 16'd1234;
        chan_in_num    = 7'd3;
        chan_in_valid  = 1'b1;
        clear_state    = 1'b1;
        tick();
        clear_state   = 1'b0;
        chan_in_valid = 1'b0;
        check("idle_clear_read", 32'(chan_in_read), 0);
        clear_model();
        wait_ready(n);
        check("idle_clear_len", n, 32);
        check("idle_clear_noout", 32'(chan_out_valid), 0);

        xact(16'h0000, 9, 65535, 1, 0, 1'b0, gu, gs);
        xact(16'hFFFF, 9, 0, 2, 0, 1'b0, gu, gs);
        check("sat_pos_u", 32'(gu), 65535);
        xact(16'h8000, 10, 65535, 1, 0, 1'b0, gu, gs);
        xact(16'h7FFF, 10, 0, 2, 0, 1'b0, gu, gs);
        check("sat_pos_s", 32'(gs), 32767);
        xact(16'h7FFF, 11, 65535, 1, 0, 1'b0, gu, gs);
        xact(16'h8000, 11, 0, 3, 0, 1'b0, gu, gs);
        check("sat_neg_s", 32'(gs), 32'h8000);

        xact(16'h1234, 40, 30000, 2, 0, 1'b0, gu, gs);
        check("oor_pass_u", 32'(gu), 32'h1234);
        check("oor_pass_s", 32'(gs), 32'h1234);

        for (int i = 0; i < 40; i++) begin
            xact(16'($urandom), int'($urandom_range(0, 35)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, gu, gs);
        end

        chan_in_sample = 16'd5000;
        chan_in_num    = 7'd3;
        chan_in_valid  = 1'b1;
        wait_ready(n);
        tick();
        chan_in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("midrst_valid", 32'(chan_out_valid), 0);
        check("midrst_read", 32'(chan_in_read), 0);
        reset = 1'b1;
        clear_model();
        wait_ready(n);
        check("midrst_clear_len", n, 32);
        check("midrst_noout", 32'(chan_out_valid), 0);
        xact(16'd33768, 3, 32768, 2, 0, 1'b0, gu, gs);
        check("hp_after_reset", 32'(gu), 33268);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cust_iir_filter_mc.md
Name: cust_iir_filter_mc

Overview:
Parametrised multi-channel first-order IIR filter for the stimulation controller datapath, successor to the single-mode HP filter. Selectable bypass/low-pass/high-pass mode, configurable widths and channel count, offset-binary or signed samples, per-channel state clear, and stall-tolerant valid/read handshakes. Sits between the RHD2000 sample stream and spike-detection/stimulation-trigger logic.

Parameters:
DATA_WIDTH, 16, sample width in bits.
COEFF_WIDTH, 16, coefficient width; coeff = round((1-exp(-2*pi*fc/fs))*2^COEFF_WIDTH).
CHANNELS, 32, number of filtered channels (state entries).
CHANNELS_PW2, 7, width of channel number ports.
SIGNED_IN, 0, 0 = offset-binary samples (2^(DATA_WIDTH-1) = zero), 1 = two's complement.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
chan_in_sample  in  DATA_WIDTH  input sample
chan_in_num  in  CHANNELS_PW2  input channel index
chan_in_valid  in  1  input sample present
chan_in_read  out  1  block accepts input this cycle
chan_out_sample  out  DATA_WIDTH  filtered sample, same format as input
chan_out_num  out  CHANNELS_PW2  channel index of output
chan_out_valid  out  1  output present
chan_out_read  in  1  downstream consumes output
coeff  in  COEFF_WIDTH  unsigned fractional coefficient
mode  in  2  00 bypass, 01 low-pass, 10/11 high-pass
clear_state  in  1  pulse: zero all channel states

Behaviour:
- Reset (reset low, async): chan_in_read=0, chan_out_valid=0, chan_out_sample=0, chan_out_num=0; FSM enters CLEAR on release.
- FSM states: CLEAR, IDLE, READ, CALC, WRITE, OUT.
- CLEAR: counter 0..CHANNELS-1 writes zero to one state entry per cycle (CHANNELS cycles), then IDLE. chan_in_read=0 throughout.
- IDLE: chan_in_read=1. Accept when chan_in_valid&&chan_in_read: register sample, num, coeff, mode -> READ. A clear_state high in IDLE takes priority over a simultaneous valid input (input not accepted) -> CLEAR.
- clear_state asserted in any other state is latched; CLEAR entered on the next return to IDLE after the in-flight sample leaves OUT.
- READ: fetch state S[num] (signed, DATA_WIDTH+COEFF_WIDTH, Q.COEFF_WIDTH) -> CALC.
- CALC: x = sample (MSB inverted if SIGNED_IN=0); lp = S>>>COEFF_WIDTH; d = x-lp (DATA_WIDTH+1 bits); S_new = S + d*{1'b0,coeff} -> WRITE.
- WRITE: store S_new; lp_new = S_new>>>COEFF_WIDTH; result: bypass -> x; low-pass -> lp_new; high-pass -> sat(x-lp_new) clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; re-apply MSB inversion if SIGNED_IN=0 -> OUT.
- Bypass mode still updates state (mode switches are glitch-free).
- chan_in_num >= CHANNELS: sample passed unmodified (bypass), no state read/write.
- OUT: chan_out_valid=1, sample/num stable; leaves when chan_out_read=1 (same-cycle consume), returns IDLE next cycle. Held indefinitely while chan_out_read=0.
- Latency acceptance->chan_out_valid: 4 cycles; throughput 1 sample per 5 cycles with chan_out_read tied high.
- coeff/mode changes after acceptance do not affect the in-flight sample.
- Reset mid-operation: in-flight sample discarded, full CLEAR sweep repeated.

Test Plan:
- Reset release -> chan_in_read low exactly CHANNELS (32) cycles, then high; all outputs 0 during reset.
- SIGNED_IN=0, mode=10, coeff=32768, ch 3, two inputs 33768 -> outputs 33268 then 33018 (HP 500, 250); chan_out_num=3, latency 4 cycles.
- Same stimulus, mode=01 -> outputs 33268 then 33518 (LP 500, 750); interleaved ch 3/ch 5 show independent state.
- chan_out_read held low 10 cycles -> chan_out_valid and data stable, chan_in_read stays low, no sample lost or duplicated.
- clear_state during CALC -> current output completes, CLEAR runs 32 cycles, next sample on ch 3 behaves as from zero state (first HP output 33268 again).
- HP saturation: coeff=0, SIGNED_IN=1, state preloaded lp=-32768 via prior LP run, input 32767 -> output 32767 (clamped); chan_in_num=40 -> sample returned unchanged.
